dmem_ctrl: RTL and testbench

Data-side access controller placed between the CPU load/store stage and the data port of the unified word-wide block-RAM memory. The memory supports only whole-word, synchronous-read accesses with 1-cycle read latency. This block adds RV32 byte and halfword loads with sign/zero extension, and implements sub-word stores as a read-modify-write sequence. It also provides a valid/ready request handshake and one response pulse per request, flags misaligned and out-of-range accesses, and stalls the requester while busy.

---
 rtl/dmem_ctrl.sv | 131 +++++++++++++
 tb/tb_dmem_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-side access controller: adds byte/half loads with extension and sub-word
// stores (read-modify-write) on top of a word-wide, 1-cycle-latency block RAM.
module dmem_ctrl #(
  parameter int WORD_LEN = 32,
  parameter int AWIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);
  localparam int NUM_LANES = WORD_LEN / 8;

  typedef enum logic [2:0] {ST_IDLE, ST_LD_WAIT, ST_RD, ST_WR, ST_ERR} state_t;

  typedef struct packed {
    logic [WORD_LEN-1:0] addr;
    logic [1:0]          size;
    logic                uns;
  } req_t;

  state_t              state;
  req_t                lat;
  logic [WORD_LEN-1:0] wbuf;   // store data, then the merged word for sub-word stores

  logic accept, req_bad;
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign req_bad   = (req_size == 2'd3)
                   | ((req_size == 2'd1) & req_addr[0])
                   | ((req_size == 2'd2) & (|req_addr[1:0]))
                   | (|req_addr[WORD_LEN-1:AWIDTH]);

  // Read is issued straight from the request in IDLE so data lands next cycle.
  assign mem_addr  = (state == ST_IDLE) ? {req_addr[WORD_LEN-1:2], 2'b00}
                                        : {lat.addr[WORD_LEN-1:2], 2'b00};
  assign mem_wen   = (state == ST_WR) & rst_n;
  assign mem_wdata = wbuf;

  // Load lane select and extension
  logic [NUM_LANES-1:0][7:0] rd_lanes;
  logic [7:0]                ld_b;
  logic [15:0]               ld_h;
  logic [WORD_LEN-1:0]       ld_data;

  assign rd_lanes = mem_rdata;
  assign ld_b     = rd_lanes[lat.addr[1:0]];
  assign ld_h     = lat.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_data = mem_rdata;
    case (lat.size)
      2'd0: ld_data = lat.uns ? {{(WORD_LEN-8){1'b0}}, ld_b}
                              : {{(WORD_LEN-8){ld_b[7]}}, ld_b};
      2'd1: ld_data = lat.uns ? {{(WORD_LEN-16){1'b0}}, ld_h}
                              : {{(WORD_LEN-16){ld_h[15]}}, ld_h};
      default: ld_data = mem_rdata;
    endcase
  end

  // Store merge: enabled lanes take store bytes, the rest keep the read word
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] mrg;

  genvar g;
  for (g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [1:0] LN = 2'(g);
    assign be[g]  = (lat.size == 2'd0) ? (lat.addr[1:0] == LN) : (lat.addr[1] == LN[1]);
    assign mrg[g] = !be[g]             ? rd_lanes[g] :
                    (lat.size == 2'd0) ? wbuf[7:0]   :
                    (LN[0] ? wbuf[15:8] : wbuf[7:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat        <= '0;
      wbuf       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          lat  <= '{addr: req_addr, size: req_size, uns: req_unsigned};
          wbuf <= req_wdata;
          if (req_bad)                state <= ST_ERR;
          else if (!req_we)           state <= ST_LD_WAIT;
          else if (req_size == 2'd2)  state <= ST_WR;
          else                        state <= ST_RD;
        end
        ST_LD_WAIT: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= ld_data;
          state      <= ST_IDLE;
        end
        ST_RD: begin
          wbuf  <= mrg;
          state <= ST_WR;
        end
        ST_WR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= ST_IDLE;
        end
        ST_ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural 1-cycle block RAM.
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dmem_ctrl #(.WORD_LEN(32), .AWIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr[15:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[15:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_cnt = 0;
  int          wr_cyc = 0;
  logic [31:0] wr_dat = '0;
  always @(negedge clk) if (mem_wen) begin
    wr_cnt <= wr_cnt + 1;
    wr_cyc <= cyc;
    wr_dat <= mem_wdata;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  task automatic set_req(input vec_t v);
    req_we = v.we; req_size = v.sz; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wd;
  endtask

  // One isolated request: returns accept cycle, latency and response fields.
  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output int n, output int lat, output logic [31:0] rd, output logic er);
    bit got;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    n = cyc;
    @(posedge clk); #1 req_valid = 1'b0;
    got = 0; lat = -1; rd = 'x; er = 1'bx;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1; lat = cyc - n; rd = resp_rdata; er = resp_err; end
    end
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp);
    int n, lat; logic [31:0] rd; logic er;
    txn(tag, 1'b0, sz, uns, addr, 32'h0, n, lat, rd, er);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_err"}, 32'(er), 32'd0);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_word, input int exp_lat);
    int n, lat, w0; logic [31:0] rd; logic er;
    w0 = wr_cnt;
    txn(tag, 1'b1, sz, 1'b0, addr, wd, n, lat, rd, er);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(er), 32'd0);
    chk({tag, "_rdata"}, rd, 32'h0);
    chk({tag, "_wcnt"}, 32'(wr_cnt - w0), 32'd1);
    chk({tag, "_wcyc"}, 32'(wr_cyc - n), 32'(exp_lat - 1));
    chk({tag, "_wdat"}, wr_dat, exp_word);
  endtask

  task automatic bad(input string tag, input logic we, input logic [1:0] sz, input logic [31:0] addr);
    int n, lat, w0; logic [31:0] rd; logic er;
    w0 = wr_cnt;
    txn(tag, we, sz, 1'b0, addr, 32'hFFFF_FFFF, n, lat, rd, er);
    chk({tag, "_err"}, 32'(er), 32'd1);
    chk({tag, "_rdata"}, rd, 32'h0);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_nowr"}, 32'(wr_cnt - w0), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t bb[5];
    int   acc_c[5], rsp_c[5];
    int   ai, ri, w0;
    bit   acc;

    for (int i = 0; i < 16384; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Word store then load
    store("sw100", 2'd2, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 2);
    load("lw100", 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);

    // Byte store read-modify-write
    store("sw200", 2'd2, 32'h200, 32'h11223344, 32'h11223344, 2);
    store("sb202", 2'd0, 32'h202, 32'h123456AA, 32'h11AA3344, 3);
    load("lw200", 2'd2, 1'b0, 32'h200, 32'h11AA3344);

    // Sub-word loads with extension
    store("sw300", 2'd2, 32'h300, 32'h8001F07F, 32'h8001F07F, 2);
    load("lb300",  2'd0, 1'b0, 32'h300, 32'h0000007F);
    load("lb301",  2'd0, 1'b0, 32'h301, 32'hFFFFFFF0);
    load("lbu301", 2'd0, 1'b1, 32'h301, 32'h000000F0);
    load("lh302",  2'd1, 1'b0, 32'h302, 32'hFFFF8001);
    load("lhu302", 2'd1, 1'b1, 32'h302, 32'h00008001);
    load("lh300",  2'd1, 1'b0, 32'h300, 32'hFFFFF07F);
    load("lb303",  2'd0, 1'b0, 32'h303, 32'hFFFFFF80);

    // Half store into upper lane
    store("sh302", 2'd1, 32'h302, 32'h5555CAFE, 32'hCAFEF07F, 3);
    load("lw300", 2'd2, 1'b0, 32'h300, 32'hCAFEF07F);

    // Error cases
    bad("lw103", 1'b0, 2'd2, 32'h103);
    bad("sh105", 1'b1, 2'd1, 32'h105);
    bad("sz3",   1'b0, 2'd3, 32'h100);
    bad("lw10000", 1'b0, 2'd2, 32'h10000);
    bad("sw10000", 1'b1, 2'd2, 32'h10000);
    chk("mem100_kept", mem[32'h100 >> 2], 32'hDEADBEEF);

    // Back-to-back with req_valid held high
    bb[0] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0};
    bb[1] = '{1'b0, 2'd0, 1'b1, 32'h301, 32'h0, 32'h000000F0, 1'b0};
    bb[2] = '{1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, 32'h0, 1'b0};
    bb[3] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h12345678, 1'b0};
    bb[4] = '{1'b0, 2'd2, 1'b0, 32'h103, 32'h0, 32'h0, 1'b1};
    ai = 0; ri = 0;
    @(negedge clk);
    set_req(bb[0]); req_valid = 1'b1;
    for (int c = 0; c < 40 && ri < 5; c++) begin
      if (resp_valid) begin
        rsp_c[ri] = cyc;
        chk($sformatf("bb%0d_data", ri), resp_rdata, bb[ri].exp);
        chk($sformatf("bb%0d_err", ri), 32'(resp_err), 32'(bb[ri].err));
        ri++;
      end
      acc = req_valid && req_ready;
      if (acc) acc_c[ai] = cyc;
      @(posedge clk); #1;
      if (acc) begin
        ai++;
        if (ai < 5) set_req(bb[ai]); else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bb_resp_cnt", 32'(ri), 32'd5);
    chk("bb_acc_cnt", 32'(ai), 32'd5);
    for (int i = 1; i < 5; i++)
      if (i < ri && i < ai) chk($sformatf("bb%0d_acc_at_resp", i), 32'(acc_c[i]), 32'(rsp_c[i-1]));
    for (int i = 0; i < 3; i++) begin
      chk("bb_no_extra", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end

    // Reset during ST_RD of a half store
    w0 = wr_cnt;
    req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h202; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_wen", 32'(mem_wen), 32'd0);
      chk("rstmid_valid", 32'(resp_valid), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    chk("rstmid_valid2", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("rstmid_nowr", 32'(wr_cnt - w0), 32'd0);
    chk("rstmid_mem", mem[32'h200 >> 2], 32'h11AA3344);
    load("lw200_after", 2'd2, 1'b0, 32'h200, 32'h11AA3344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
